car_shaft_drive: RTL and testbench

//  Car-side motion responder: the deterministic counterpart to the car's random r_stop arrival model.

---
 rtl/elevator_pkg.sv | 26 ++
 rtl/drive_timer.sv | 28 ++
 rtl/car_shaft_drive.sv | 137 +++++++++++++
 tb/tb_car_shaft_drive.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared elevator types and floor constants.
// Used by main_control, elevator and car_shaft_drive.
package elevator_pkg;

  localparam int FLOORS = 3;
  localparam int LOC_W  = 2;
  localparam int CNT_W  = 8;

  typedef enum logic {
    DOWN = 1'b0,
    UP   = 1'b1
  } dir_t;

  typedef enum logic {
    STOPPED = 1'b0,
    MOVING  = 1'b1
  } mov_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    ARRIVE = 2'd2,
    SETTLE = 2'd3
  } drive_state_t;

endpackage

// File: rtl/drive_timer.sv
// Loadable down-counter shared by the RUN and SETTLE phases.
// Ports: load/val reload, dec counts down (stops at 0), zero flags 0.
module drive_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/car_shaft_drive.sv
// Car-side motion responder: times one-floor runs and emits inc/dec pulses.
// Ports: move_req/move_up/abort in; ready, moving, inc, dec, location, fault out.
module car_shaft_drive
  import elevator_pkg::*;
#(
  parameter int FLOORS_P      = FLOORS,
  parameter int LOC_W_P       = LOC_W,
  parameter int TRAVEL_CYCLES = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LOC_W_P-1:0] init_floor,
  input  logic               move_req,
  input  logic               move_up,
  input  logic               abort,
  output logic               ready,
  output logic               moving,
  output logic               inc,
  output logic               dec,
  output logic [LOC_W_P-1:0] location,
  output logic               fault
);

  localparam logic [LOC_W_P-1:0] TOP =
    LOC_W_P'(FLOORS_P - 1);
  localparam logic [CNT_W-1:0] RUN_LD =
    CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] SET_LD =
    CNT_W'(SETTLE_CYCLES - 1);

  drive_state_t st, nxt;
  dir_t         dir_q;
  mov_t         mov;

  logic             t_load;
  logic [CNT_W-1:0] t_val;
  logic             t_dec;
  logic             t_zero;
  logic             accept;
  logic             fault_set;
  logic             legal;
  logic [LOC_W_P-1:0] init_cl;

  assign init_cl = (init_floor > TOP) ? TOP : init_floor;

  assign legal = move_up ? (location != TOP)
                         : (location != '0);

  drive_timer #(.W(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (t_load),
    .val   (t_val),
    .dec   (t_dec),
    .zero  (t_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st       <= IDLE;
      dir_q    <= DOWN;
      location <= init_cl;
      fault    <= 1'b0;
    end else begin
      st <= nxt;
      if (accept) begin
        dir_q <= move_up ? UP : DOWN;
      end
      if (fault_set) begin
        fault <= 1'b1;
      end
      if (st == ARRIVE) begin
        location <= (dir_q == UP)
                  ? location + LOC_W_P'(1)
                  : location - LOC_W_P'(1);
      end
    end
  end

  always_comb begin
    nxt       = st;
    t_load    = 1'b0;
    t_val     = '0;
    t_dec     = 1'b0;
    accept    = 1'b0;
    fault_set = 1'b0;
    unique case (st)
      IDLE: begin
        // abort drops any request made in the same cycle
        if (!abort && move_req) begin
          if (legal) begin
            nxt    = RUN;
            t_load = 1'b1;
            t_val  = RUN_LD;
            accept = 1'b1;
          end else begin
            fault_set = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          nxt = IDLE;
        end else if (t_zero) begin
          nxt = ARRIVE;
        end else begin
          t_dec = 1'b1;
        end
      end
      ARRIVE: begin
        // pulse and floor update still complete under abort
        if (abort) begin
          nxt = IDLE;
        end else begin
          nxt    = SETTLE;
          t_load = 1'b1;
          t_val  = SET_LD;
        end
      end
      SETTLE: begin
        if (abort || t_zero) begin
          nxt = IDLE;
        end else begin
          t_dec = 1'b1;
        end
      end
    endcase
  end

  assign mov    = (st == RUN) ? MOVING : STOPPED;
  assign moving = (mov == MOVING);
  assign ready  = (st == IDLE);
  assign inc    = (st == ARRIVE) && (dir_q == UP);
  assign dec    = (st == ARRIVE) && (dir_q == DOWN);

endmodule

// File: tb/tb_car_shaft_drive.sv
// Testbench for car_shaft_drive.
// Scenario tasks plus a pulse scoreboard keyed on cycle number.
module tb_car_shaft_drive;

  localparam int TRAVEL = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] init_floor;
  logic       move_req;
  logic       move_up;
  logic       abort;
  logic       ready;
  logic       moving;
  logic       inc;
  logic       dec;
  logic [1:0] location;
  logic       fault;

  typedef struct {
    int cyc;
    bit up;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   checks;
  int   errors;
  bit   sb_on;

  car_shaft_drive dut (
    .clk        (clk),
    .reset      (reset),
    .init_floor (init_floor),
    .move_req   (move_req),
    .move_up    (move_up),
    .abort      (abort),
    .ready      (ready),
    .moving     (moving),
    .inc        (inc),
    .dec        (dec),
    .location   (location),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (sb_on && !reset && (inc || dec)) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pulse_unexpected cyc=%0d inc=%b dec=%b",
                 cyc, inc, dec);
      end else begin
        e = exp_q.pop_front();
        if (cyc !== e.cyc || inc !== e.up || dec !== !e.up) begin
          errors++;
          $display("FAIL pulse cyc=%0d inc=%b dec=%b exp cyc=%0d up=%b",
                   cyc, inc, dec, e.cyc, e.up);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [1:0] f);
    tick();
    reset      = 1'b1;
    init_floor = f;
    move_req   = 1'b0;
    move_up    = 1'b0;
    abort      = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic q_empty(input string nm);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s pending=%0d exp=0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    tick();
    reset      = 1'b1;
    init_floor = 2'd0;
    move_req   = 1'b1;
    move_up    = 1'b1;
    abort      = 1'b0;
    tick();
    checks++;
    if ({inc, dec, moving, fault, location} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outs got=%b exp=000000",
               {inc, dec, moving, fault, location});
    end
    move_req = 1'b0;
    reset    = 1'b0;
    tick();
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got=%b exp=1", ready);
    end
  endtask

  task automatic test_single_up();
    int c;
    do_reset(2'd0);
    c = cyc;
    move_req = 1'b1;
    move_up  = 1'b1;
    exp_q.push_back('{c + 1 + TRAVEL, 1'b1});
    tick();
    move_req = 1'b0;
    checks++;
    if (moving !== 1'b1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL single_run moving=%b ready=%b exp 1/0",
               moving, ready);
    end
    repeat (6) tick();
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL single_settle ready=%b exp=0", ready);
    end
    tick();
    checks++;
    if (ready !== 1'b1 || location !== 2'd1) begin
      errors++;
      $display("FAIL single_done ready=%b loc=%0d exp 1/1",
               ready, location);
    end
    q_empty("single_q");
  endtask

  task automatic test_top_fault();
    int c;
    do_reset(2'd3);
    checks++;
    if (location !== 2'd2) begin
      errors++;
      $display("FAIL clamp loc=%0d exp=2", location);
    end
    move_req = 1'b1;
    move_up  = 1'b1;
    tick();
    move_req = 1'b0;
    checks++;
    if (fault !== 1'b1 || ready !== 1'b1 || location !== 2'd2) begin
      errors++;
      $display("FAIL top_fault f=%b r=%b loc=%0d exp 1/1/2",
               fault, ready, location);
    end
    c = cyc;
    move_req = 1'b1;
    move_up  = 1'b0;
    exp_q.push_back('{c + 1 + TRAVEL, 1'b0});
    tick();
    move_req = 1'b0;
    repeat (8) tick();
    checks++;
    if (location !== 2'd1 || fault !== 1'b1) begin
      errors++;
      $display("FAIL down_after loc=%0d f=%b exp 1/1",
               location, fault);
    end
    q_empty("fault_q");
  endtask

  task automatic test_back_to_back();
    int c;
    bit over;
    do_reset(2'd0);
    over = 1'b0;
    c = cyc;
    move_req = 1'b1;
    move_up  = 1'b1;
    exp_q.push_back('{c + 1 + TRAVEL, 1'b1});
    exp_q.push_back('{c + 9 + TRAVEL, 1'b1});
    repeat (30) begin
      tick();
      if (location > 2'd2) over = 1'b1;
    end
    move_req = 1'b0;
    checks++;
    if (over) begin
      errors++;
      $display("FAIL b2b_range loc went past top exp<=2");
    end
    checks++;
    if (location !== 2'd2 || fault !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end loc=%0d f=%b exp 2/1",
               location, fault);
    end
    q_empty("b2b_q");
  endtask

  task automatic test_abort();
    do_reset(2'd1);
    move_req = 1'b1;
    move_up  = 1'b0;
    tick();
    move_req = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (ready !== 1'b1 || moving !== 1'b0 || location !== 2'd1) begin
      errors++;
      $display("FAIL abort_run r=%b m=%b loc=%0d exp 1/0/1",
               ready, moving, location);
    end
    abort    = 1'b1;
    move_req = 1'b1;
    tick();
    abort    = 1'b0;
    move_req = 1'b0;
    checks++;
    if (ready !== 1'b1 || moving !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle r=%b m=%b exp 1/0", ready, moving);
    end
    repeat (10) tick();
    checks++;
    if (location !== 2'd1) begin
      errors++;
      $display("FAIL abort_loc loc=%0d exp=1", location);
    end
    q_empty("abort_q");
  endtask

  task automatic test_reset_mid_run();
    do_reset(2'd0);
    move_req = 1'b1;
    move_up  = 1'b1;
    tick();
    move_req = 1'b0;
    tick();
    reset      = 1'b1;
    init_floor = 2'd1;
    #1;
    checks++;
    if ({inc, dec, moving, fault} !== 4'b0 || ready !== 1'b1 ||
        location !== 2'd1) begin
      errors++;
      $display("FAIL rst_mid idm=%b%b%b f=%b r=%b loc=%0d exp 000/0/1/1",
               inc, dec, moving, fault, ready, location);
    end
    tick();
    reset = 1'b0;
    repeat (10) tick();
    checks++;
    if (location !== 2'd1) begin
      errors++;
      $display("FAIL rst_mid_loc loc=%0d exp=1", location);
    end
    q_empty("rst_mid_q");
  endtask

  task automatic test_random();
    int ni;
    int nd;
    int loc0;
    bit both;
    bit range;
    do_reset(2'($urandom_range(0, 2)));
    sb_on = 1'b0;
    loc0  = int'(location);
    ni = 0;
    nd = 0;
    both  = 1'b0;
    range = 1'b0;
    repeat (10000) begin
      tick();
      if (inc && dec) both = 1'b1;
      if (location > 2'd2) range = 1'b1;
      if (inc) ni++;
      if (dec) nd++;
      move_req = 1'($urandom_range(0, 1));
      move_up  = 1'($urandom_range(0, 1));
      abort    = ($urandom_range(0, 15) == 0);
    end
    move_req = 1'b0;
    abort    = 1'b0;
    repeat (12) begin
      tick();
      if (inc && dec) both = 1'b1;
      if (inc) ni++;
      if (dec) nd++;
    end
    checks++;
    if (both) begin
      errors++;
      $display("FAIL rnd_both inc&dec seen exp never");
    end
    checks++;
    if (range) begin
      errors++;
      $display("FAIL rnd_range loc>2 seen exp 0..2");
    end
    checks++;
    if (int'(location) != loc0 + ni - nd) begin
      errors++;
      $display("FAIL rnd_delta loc=%0d exp=%0d", location,
               loc0 + ni - nd);
    end
    checks++;
    if (ni + nd == 0) begin
      errors++;
      $display("FAIL rnd_activity pulses=0 exp>0");
    end
    sb_on = 1'b1;
  endtask

  initial begin
    cyc        = 0;
    checks     = 0;
    errors     = 0;
    sb_on      = 1'b1;
    reset      = 1'b1;
    init_floor = 2'd0;
    move_req   = 1'b0;
    move_up    = 1'b0;
    abort      = 1'b0;
    test_reset();
    test_single_up();
    test_top_fault();
    test_back_to_back();
    test_abort();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
